dac_hpf_scheduler: RTL and testbench
====================================

Name: dac_hpf_scheduler

Overview:
- Time-multiplexes one shared first-order high-pass filter (HPF) arithmetic unit across the 8 DAC output channels.
- Once per amplifier sample frame, it snapshots the 8 raw DAC words and walks the channels in order.
- For each enabled channel, it either requests a filter operation or bypasses the filter.
- It then presents all 8 results to the DAC serializer atomically, with a one-cycle load strobe.

Parameters:
- NUM_DAC, 8, number of DAC channels served (2..8).
- DATA_W, 16, DAC word width (offset binary, midscale 16'h8000).
- TIMEOUT_CYC, 64, maximum cycles to wait for filt_ack (used only with the optional feature).

Ports:
- dataclk  in  1  system data clock; all logic is rising-edge.
- reset_n  in  1  asynchronous active-low reset.
- sample_start  in  1  one-cycle pulse marking the start of a sample frame.
- hpf_en  in  1  global HPF enable; sampled at snapshot.
- dac_en  in  NUM_DAC  per-channel enable; sampled at snapshot.
- dac_in_flat  in  NUM_DAC*DATA_W  raw DAC words; channel k occupies bits [k*DATA_W +: DATA_W].
- filt_req  out  1  request to the shared HPF unit.
- filt_ch  out  3  channel index of the current request.
- filt_x  out  DATA_W  input sample for the current request.
- filt_ack  in  1  HPF unit completion; filt_y is valid in the same cycle.
- filt_y  in  DATA_W  filtered result.
- dac_out_flat  out  NUM_DAC*DATA_W  shadow outputs to the DAC serializer.
- dac_load  out  1  one-cycle strobe: dac_out_flat has just been updated.
- busy  out  1  high while the scheduler is not IDLE.
- overrun  out  1  sticky: sample_start arrived while busy.
- fault  out  1  sticky: filter timeout occurred (only with the optional feature; tied 0 otherwise).
- flag_clr  in  1  synchronous clear of overrun and fault.

Behaviour:
- Reset values:
  - All outputs 0, except every dac_out_flat word = 16'h8000.
  - State = IDLE, ch = 0.
- States: IDLE, CHECK, REQ, DONE.
- IDLE:
  - On sample_start, snapshot dac_in_flat, dac_en and hpf_en into internal registers.
  - Set ch = 0 and go to CHECK.
- CHECK (one cycle per channel):
  - If dac_en[ch] = 0: result[ch] = 16'h8000.
  - Else if hpf_en = 0: result[ch] = snapshot[ch] (bypass).
  - Else: go to REQ without advancing ch.
  - In the two non-REQ cases: if ch = NUM_DAC-1, go to DONE; otherwise ch++ and stay in CHECK.
- REQ:
  - filt_req = 1 with filt_ch = ch and filt_x = snapshot[ch], all held stable until filt_ack is sampled high.
  - On filt_ack: result[ch] = filt_y and filt_req drops on the next cycle.
  - Then advance ch or go to DONE, using the same rule as CHECK.
  - filt_ack while filt_req = 0 is ignored.
- DONE:
  - One cycle: dac_out_flat <= result (all words update on the same edge), dac_load = 1.
  - Return to IDLE.
- Latency, measured from the edge that samples sample_start:
  - All channels bypassed: dac_load high exactly NUM_DAC+1 cycles later.
  - Each filtered channel adds 1 + (ack wait) cycles.
- dac_out_flat is held between loads; words never change outside DONE.
- sample_start while busy:
  - The pulse is ignored and does not restart the frame.
  - overrun is set in the following cycle.
- sample_start in the DONE cycle also counts as busy.
- flag_clr and a set event in the same cycle: set wins.
- Channel index wrap: ch never exceeds NUM_DAC-1 and resets to 0 in IDLE.
- Reset mid-frame (reset_n low at any time): immediate return to reset values; filt_req drops asynchronously; the partial frame is discarded with no dac_load.
- busy = (state != IDLE).

Optional Feature:
- Macro: DAC_HPF_TIMEOUT_EN.
- Defined:
  - A counter runs in REQ.
  - If filt_ack is not seen within TIMEOUT_CYC cycles, the request is abandoned: filt_req drops, result[ch] = snapshot[ch] (bypass value), fault is set (sticky), and the scheduler advances.
  - An ack arriving in the same cycle the timeout expires is accepted; no fault is raised.
- Undefined: REQ waits indefinitely and fault is tied 0.

Test Plan:
- Reset, then sample_start with dac_en=8'hFF, hpf_en=0, channel k = 16'h1000+k → dac_load exactly 9 cycles after start; outputs 16'h1000..16'h1007; filt_req never asserted.
- dac_en=8'b1010_0101, hpf_en=0 → disabled channels 1,3,4,6 read 16'h8000; enabled channels pass their raw value.
- hpf_en=1, dac_en=8'hFF, model ack after 3 cycles returning filt_y = filt_x ^ 16'hFFFF → filt_ch sequence 0..7 in order; filt_x stable while filt_req is high; outputs are the inverted inputs; dac_load once.
- Second sample_start 4 cycles into a frame → overrun=1, frame completes normally, single dac_load; flag_clr → overrun=0.
- reset_n low while in REQ on channel 3 → filt_req=0 immediately; dac_out_flat all 16'h8000; no dac_load.
- With DAC_HPF_TIMEOUT_EN, TIMEOUT_CYC=64: ack never returned on channel 2 → fault=1, channel 2 output = raw value, remaining channels filtered, dac_load issued.

Source files
------------

// File: rtl/dac_hpf_scheduler.sv
// Shares one first-order HPF unit across NUM_DAC DAC channels, once per sample frame.
// Optional macro DAC_HPF_TIMEOUT_EN: abandon a filter request after TIMEOUT_CYC cycles and flag fault.
module dac_hpf_scheduler #(
    parameter int NUM_DAC     = 8,
    parameter int DATA_W      = 16,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                      dataclk,
    input  logic                      reset_n,
    input  logic                      sample_start,
    input  logic                      hpf_en,
    input  logic [NUM_DAC-1:0]        dac_en,
    input  logic [NUM_DAC*DATA_W-1:0] dac_in_flat,
    output logic                      filt_req,
    output logic [2:0]                filt_ch,
    output logic [DATA_W-1:0]         filt_x,
    input  logic                      filt_ack,
    input  logic [DATA_W-1:0]         filt_y,
    output logic [NUM_DAC*DATA_W-1:0] dac_out_flat,
    output logic                      dac_load,
    output logic                      busy,
    output logic                      overrun,
    output logic                      fault,
    input  logic                      flag_clr
);

    localparam logic [DATA_W-1:0] MIDSCALE = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [2:0]        LAST_CH  = 3'(NUM_DAC - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_REQ   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    if (NUM_DAC < 2 || NUM_DAC > 8 || TIMEOUT_CYC < 1) begin : g_param_guard
        $error("dac_hpf_scheduler: parameter out of range");
    end

    state_t              state_q;
    logic [2:0]          ch_q;
    logic [2:0]          ch_d;
    logic                ch_last_s;
    logic                filter_s;
    logic [DATA_W-1:0]   bypass_s;
    logic [NUM_DAC-1:0]  en_q;
    logic                hpf_q;
    logic [DATA_W-1:0]   snap_q [NUM_DAC];
    logic [DATA_W-1:0]   res_q  [NUM_DAC];
    logic [DATA_W-1:0]   out_q  [NUM_DAC];
    logic                filt_req_q;
    logic [2:0]          filt_ch_q;
    logic [DATA_W-1:0]   filt_x_q;
    logic                dac_load_q;
    logic                overrun_q;

`ifdef DAC_HPF_TIMEOUT_EN
    localparam int              TMO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    logic [TMO_W-1:0] tmo_q;
    logic             fault_q;
    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    // Per-channel decisions: next index, whether to filter, and the non-filtered result value.
    always_comb begin
        ch_last_s = (ch_q == LAST_CH);
        if (ch_last_s) begin
            ch_d = ch_q;
        end else begin
            ch_d = ch_q + 3'd1;
        end
        filter_s = en_q[ch_q] & hpf_q;
        if (en_q[ch_q]) begin
            bypass_s = snap_q[ch_q];
        end else begin
            bypass_s = MIDSCALE;
        end
    end

    // Scheduler FSM with snapshot, result and shadow-output registers.
    always_ff @(posedge dataclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            ch_q       <= 3'd0;
            en_q       <= {NUM_DAC{1'b0}};
            hpf_q      <= 1'b0;
            filt_req_q <= 1'b0;
            filt_ch_q  <= 3'd0;
            filt_x_q   <= {DATA_W{1'b0}};
            dac_load_q <= 1'b0;
            overrun_q  <= 1'b0;
            for (int k = 0; k < NUM_DAC; k++) begin
                snap_q[k] <= {DATA_W{1'b0}};
                res_q[k]  <= MIDSCALE;
                out_q[k]  <= MIDSCALE;
            end
`ifdef DAC_HPF_TIMEOUT_EN
            tmo_q   <= {TMO_W{1'b0}};
            fault_q <= 1'b0;
`endif
        end else begin
            dac_load_q <= 1'b0;
            // A start pulse outside IDLE (DONE included) is dropped but remembered.
            if (sample_start && (state_q != S_IDLE)) begin
                overrun_q <= 1'b1;
            end else if (flag_clr) begin
                overrun_q <= 1'b0;
            end
`ifdef DAC_HPF_TIMEOUT_EN
            if (flag_clr) begin
                fault_q <= 1'b0;
            end
`endif
            case (state_q)
                S_IDLE: begin
                    ch_q <= 3'd0;
                    if (sample_start) begin
                        en_q    <= dac_en;
                        hpf_q   <= hpf_en;
                        for (int k = 0; k < NUM_DAC; k++) begin
                            snap_q[k] <= dac_in_flat[k*DATA_W +: DATA_W];
                        end
                        state_q <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (filter_s) begin
                        filt_req_q <= 1'b1;
                        filt_ch_q  <= ch_q;
                        filt_x_q   <= snap_q[ch_q];
`ifdef DAC_HPF_TIMEOUT_EN
                        tmo_q      <= {TMO_W{1'b0}};
`endif
                        state_q    <= S_REQ;
                    end else begin
                        res_q[ch_q] <= bypass_s;
                        ch_q        <= ch_d;
                        state_q     <= ch_last_s ? S_DONE : S_CHECK;
                    end
                end
                S_REQ: begin
                    // An ack on the expiry cycle still wins over the timeout.
                    if (filt_ack) begin
                        res_q[ch_q] <= filt_y;
                        filt_req_q  <= 1'b0;
                        ch_q        <= ch_d;
                        state_q     <= ch_last_s ? S_DONE : S_CHECK;
                    end
`ifdef DAC_HPF_TIMEOUT_EN
                    else if (tmo_q == TMO_LAST) begin
                        res_q[ch_q] <= bypass_s;
                        filt_req_q  <= 1'b0;
                        fault_q     <= 1'b1;
                        ch_q        <= ch_d;
                        state_q     <= ch_last_s ? S_DONE : S_CHECK;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
`endif
                end
                S_DONE: begin
                    for (int k = 0; k < NUM_DAC; k++) begin
                        out_q[k] <= res_q[k];
                    end
                    dac_load_q <= 1'b1;
                    state_q    <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    for (genvar g = 0; g < NUM_DAC; g++) begin : g_pack
        assign dac_out_flat[g*DATA_W +: DATA_W] = out_q[g];
    end

    assign filt_req = filt_req_q;
    assign filt_ch  = filt_ch_q;
    assign filt_x   = filt_x_q;
    assign dac_load = dac_load_q;
    assign overrun  = overrun_q;
    assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_dac_hpf_scheduler.sv
// Bench for dac_hpf_scheduler: directed vector table, randomized frames against a frame-level model,
// and hand-written overrun / mid-frame reset / filter-timeout sequences.
module tb_dac_hpf_scheduler;

    localparam int NUM = 8;
    localparam int W   = 16;
    localparam int TMO = 64;

    logic           dataclk = 1'b0;
    logic           reset_n;
    logic           sample_start;
    logic           hpf_en;
    logic [NUM-1:0] dac_en;
    logic [127:0]   dac_in_flat;
    logic           filt_req;
    logic [2:0]     filt_ch;
    logic [W-1:0]   filt_x;
    logic           filt_ack;
    logic [W-1:0]   filt_y;
    logic [127:0]   dac_out_flat;
    logic           dac_load;
    logic           busy;
    logic           overrun;
    logic           fault;
    logic           flag_clr;

    dac_hpf_scheduler #(.NUM_DAC(NUM), .DATA_W(W), .TIMEOUT_CYC(TMO)) dut (
        .dataclk(dataclk), .reset_n(reset_n), .sample_start(sample_start),
        .hpf_en(hpf_en), .dac_en(dac_en), .dac_in_flat(dac_in_flat),
        .filt_req(filt_req), .filt_ch(filt_ch), .filt_x(filt_x),
        .filt_ack(filt_ack), .filt_y(filt_y), .dac_out_flat(dac_out_flat),
        .dac_load(dac_load), .busy(busy), .overrun(overrun), .fault(fault),
        .flag_clr(flag_clr)
    );

    always #5 dataclk = ~dataclk;

    int           n_cmp = 0;
    int           n_err = 0;
    int           ack_dly = 1;
    int           no_ack_ch = -1;
    logic         spurious = 1'b0;
    logic [127:0] cur_din = '0;
    int           seen_ch[$];
    logic         ovr_model = 1'b0;
    logic         fault_model = 1'b0;

    localparam logic [127:0] ALL_MID = {8{16'h8000}};

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 'h%0h, want 'h%0h", name, act, exp);
        end
    endtask

    // Frame-level reference: each word is midscale, raw, or inverted; latency adds each request's wait.
    task automatic model(input logic [127:0] din, input logic [7:0] en, input logic hpf,
                         input int dly, input int nak,
                         output logic [127:0] out, output int lat, output logic flt);
        logic [15:0] w;
        lat = NUM + 1;
        flt = 1'b0;
        out = '0;
        for (int k = 0; k < NUM; k++) begin
            w = din[k*16 +: 16];
            if (!en[k]) out[k*16 +: 16] = 16'h8000;
            else if (!hpf) out[k*16 +: 16] = w;
`ifdef DAC_HPF_TIMEOUT_EN
            else if (k == nak) begin
                out[k*16 +: 16] = w;
                lat += TMO;
                flt = 1'b1;
            end
`endif
            else begin
                out[k*16 +: 16] = w ^ 16'hFFFF;
                lat += dly;
            end
        end
    endtask

    // HPF unit stand-in: acks after ack_dly request cycles with y = x ^ FFFF; optional stray acks when idle.
    initial begin
        int cnt = 0;
        filt_ack = 1'b0;
        filt_y   = '0;
        forever begin
            @(negedge dataclk);
            if (!reset_n) begin
                cnt = 0;
                filt_ack = 1'b0;
            end else if (filt_req) begin
                cnt++;
                if (int'(filt_ch) != no_ack_ch && cnt == ack_dly) begin
                    filt_ack = 1'b1;
                    filt_y   = filt_x ^ 16'hFFFF;
                end else begin
                    filt_ack = 1'b0;
                    filt_y   = 16'($urandom);
                end
            end else begin
                cnt = 0;
                filt_ack = spurious && ($urandom_range(0, 3) == 0);
                filt_y   = 16'($urandom);
            end
        end
    end

    // Request and output-hold monitor.
    initial begin
        logic         prev_req = 1'b0;
        logic [127:0] prev_out = '0;
        logic [2:0]   req_ch = '0;
        logic [15:0]  req_x = '0;
        forever begin
            @(negedge dataclk);
            if (!reset_n) begin
                prev_req = 1'b0;
                prev_out = dac_out_flat;
            end else begin
                if (filt_req && !prev_req) begin
                    seen_ch.push_back(int'(filt_ch));
                    req_ch = filt_ch;
                    req_x  = filt_x;
                    check("filt_x", 128'(filt_x), 128'(cur_din[int'(filt_ch)*16 +: 16]));
                end else if (filt_req) begin
                    check("filt_hold", 128'({filt_ch, filt_x}), 128'({req_ch, req_x}));
                end
                if (dac_out_flat !== prev_out) check("out_hold", 128'(dac_load), 128'd1);
                prev_req = filt_req;
                prev_out = dac_out_flat;
            end
        end
    end

    task automatic run_frame(input logic [127:0] din, input logic [7:0] en, input logic hpf,
                             input int dly, input logic [127:0] exp_out, input int exp_lat,
                             input int extra_at, input logic clr_with, input string tag);
        int cyc;
        int exp_q[$];
        for (int k = 0; k < NUM; k++) if (hpf && en[k]) exp_q.push_back(k);
        seen_ch.delete();
        cur_din      = din;
        ack_dly      = dly;
        dac_in_flat  = din;
        dac_en       = en;
        hpf_en       = hpf;
        sample_start = 1'b1;
        @(negedge dataclk);
        sample_start = 1'b0;
        cyc = 0;
        while (!dac_load && cyc < 3000) begin
            dac_in_flat = {$urandom, $urandom, $urandom, $urandom};
            dac_en      = 8'($urandom);
            hpf_en      = 1'($urandom);
            sample_start = (cyc == extra_at);
            flag_clr     = (cyc == extra_at) && clr_with;
            @(negedge dataclk);
            cyc++;
        end
        sample_start = 1'b0;
        flag_clr     = 1'b0;
        if (extra_at >= 0) ovr_model = 1'b1;
        check({tag, "_latency"}, 128'(cyc), 128'(exp_lat));
        check({tag, "_dac_out"}, dac_out_flat, exp_out);
        check({tag, "_nreq"}, 128'(seen_ch.size()), 128'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < seen_ch.size(); i++)
            check($sformatf("%s_req_ch%0d", tag, i), 128'(seen_ch[i]), 128'(exp_q[i]));
        @(negedge dataclk);
        check({tag, "_load_width"}, 128'(dac_load), 128'd0);
        check({tag, "_busy_after"}, 128'(busy), 128'd0);
        check({tag, "_overrun"}, 128'(overrun), 128'(ovr_model));
        check({tag, "_fault"}, 128'(fault), 128'(fault_model));
    endtask

    task automatic clear_flags();
        flag_clr = 1'b1;
        @(negedge dataclk);
        flag_clr = 1'b0;
        ovr_model   = 1'b0;
        fault_model = 1'b0;
        check("clr_overrun", 128'(overrun), 128'd0);
        check("clr_fault", 128'(fault), 128'd0);
    endtask

    typedef struct {
        logic [127:0] din;
        logic [7:0]   en;
        logic         hpf;
        int           dly;
        logic [127:0] exp_out;
        int           exp_lat;
    } vec_t;

    vec_t vecs[5];

    initial begin
        localparam logic [127:0] D = 128'h1007_1006_1005_1004_1003_1002_1001_1000;
        logic [127:0] din, eo;
        logic [7:0]   en;
        logic         hpf, ef;
        int           dly, el;

        vecs[0] = '{D, 8'hFF, 1'b0, 1, D, 9};
        vecs[1] = '{D, 8'b1010_0101, 1'b0, 1, 128'h1007_8000_1005_8000_8000_1002_8000_1000, 9};
        vecs[2] = '{D, 8'hFF, 1'b1, 3, 128'hEFF8_EFF9_EFFA_EFFB_EFFC_EFFD_EFFE_EFFF, 33};
        vecs[3] = '{D, 8'b1010_0101, 1'b1, 1, 128'hEFF8_8000_EFFA_8000_8000_EFFD_8000_EFFF, 13};
        vecs[4] = '{D, 8'h00, 1'b1, 2, ALL_MID, 9};

        reset_n = 1'b0; sample_start = 1'b0; hpf_en = 1'b0; dac_en = '0;
        dac_in_flat = '0; flag_clr = 1'b0;
        repeat (3) @(negedge dataclk);
        reset_n = 1'b1;
        @(negedge dataclk);
        check("rst_dac_out", dac_out_flat, ALL_MID);
        check("rst_flags", 128'({filt_req, filt_ch, filt_x, dac_load, busy, overrun, fault}), 128'd0);

        foreach (vecs[i])
            run_frame(vecs[i].din, vecs[i].en, vecs[i].hpf, vecs[i].dly, vecs[i].exp_out,
                      vecs[i].exp_lat, -1, 1'b0, $sformatf("vec%0d", i));

        spurious = 1'b1;
        for (int f = 0; f < 16; f++) begin
            din = {$urandom, $urandom, $urandom, $urandom};
            en  = 8'($urandom);
            hpf = ($urandom_range(0, 3) != 0);
            dly = $urandom_range(1, 4);
            model(din, en, hpf, dly, -1, eo, el, ef);
            run_frame(din, en, hpf, dly, eo, el, -1, 1'b0, $sformatf("rnd%0d", f));
        end

        // Second start 4 cycles into a filtered frame.
        din = {$urandom, $urandom, $urandom, $urandom};
        model(din, 8'hFF, 1'b1, 2, -1, eo, el, ef);
        run_frame(din, 8'hFF, 1'b1, 2, eo, el, 3, 1'b0, "ovr_mid");
        clear_flags();

        // Start landing on the DONE cycle, then set and clear colliding on one edge.
        din = {$urandom, $urandom, $urandom, $urandom};
        run_frame(din, 8'hFF, 1'b0, 1, din, 9, 8, 1'b0, "ovr_done");
        run_frame(din, 8'h0F, 1'b0, 1, {{4{16'h8000}}, din[63:0]}, 9, 3, 1'b1, "ovr_setwins");
        clear_flags();

`ifdef DAC_HPF_TIMEOUT_EN
        din = {$urandom, $urandom, $urandom, $urandom};
        model(din, 8'h01, 1'b1, TMO, -1, eo, el, ef);
        run_frame(din, 8'h01, 1'b1, TMO, eo, el, -1, 1'b0, "tmo_edge_ack");
        no_ack_ch = 2;
        model(din, 8'hFF, 1'b1, 2, 2, eo, el, ef);
        fault_model = ef;
        run_frame(din, 8'hFF, 1'b1, 2, eo, el, -1, 1'b0, "tmo_ch2");
        no_ack_ch = -1;
        clear_flags();
`endif

        // Reset while channel 3 is waiting on the filter.
        begin
            int   cyc = 0;
            logic saw = 1'b0;
            no_ack_ch = 3;
            ack_dly   = 2;
            cur_din   = {$urandom, $urandom, $urandom, $urandom};
            dac_in_flat = cur_din; dac_en = 8'hFF; hpf_en = 1'b1; sample_start = 1'b1;
            @(negedge dataclk);
            sample_start = 1'b0;
            while (!(filt_req && filt_ch == 3'd3) && cyc < 200) begin
                @(negedge dataclk);
                cyc++;
            end
            check("rst_reach_ch3", 128'(cyc < 200), 128'd1);
            #2 reset_n = 1'b0;
            #1;
            check("rst_mid_req", 128'(filt_req), 128'd0);
            check("rst_mid_busy", 128'(busy), 128'd0);
            check("rst_mid_out", dac_out_flat, ALL_MID);
            @(negedge dataclk);
            #2 reset_n = 1'b1;
            no_ack_ch = -1;
            ovr_model = 1'b0;
            fault_model = 1'b0;
            repeat (20) begin
                @(negedge dataclk);
                if (dac_load) saw = 1'b1;
            end
            check("rst_no_load", 128'(saw), 128'd0);
        end

        din = {$urandom, $urandom, $urandom, $urandom};
        model(din, 8'h5A, 1'b1, 1, -1, eo, el, ef);
        run_frame(din, 8'h5A, 1'b1, 1, eo, el, -1, 1'b0, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
